ifft_sequential: RTL

IFFT_SEQUENTIAL -- requirements
Module: ifft_sequential

---
 rtl/ifft_sequential.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ifft_sequential.sv
// Iterative radix-2 DIT inverse FFT: one complex butterfly per clock, real part scaled by 1/N.
// Optional macro IFFT_SATURATE_EN clamps butterfly sums/differences instead of wrapping them.
module ifft_sequential #(
  parameter int twiddle_size  = 16,
  parameter int buffer_size   = 32,
  parameter int sample_size   = 32,
  parameter int no_float_mult = 1000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [buffer_size*sample_size-1:0] input_real,
  input  logic [buffer_size*sample_size-1:0] input_imag,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [buffer_size*sample_size-1:0] output_real
);

  localparam int  N     = buffer_size;
  localparam int  S     = sample_size;
  localparam int  T     = twiddle_size;
  localparam int  PW    = S + T;
  localparam int  LOG2N = $clog2(N);
  localparam int  SW    = $clog2(LOG2N + 1);
  localparam real PI    = 3.14159265358979323846;

  if ((buffer_size < 2) || ((buffer_size & (buffer_size - 1)) != 0)) begin : g_bad_size
    $error("ifft_sequential: buffer_size must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, SCALE, DONE} state_t;

  localparam logic signed [PW-1:0] NFM = PW'(no_float_mult);
`ifdef IFFT_SATURATE_EN
  localparam logic signed [PW-1:0] SMAX = $signed({{(T+1){1'b0}}, {(S-1){1'b1}}});
  localparam logic signed [PW-1:0] SMIN = -SMAX - 1;
`endif

  state_t                  state_q, state_d;
  logic [SW-1:0]           stage_q, stage_d;
  logic [LOG2N-1:0]        bfly_q, bfly_d;
  logic signed [S-1:0]     re_q [N];
  logic signed [S-1:0]     re_d [N];
  logic signed [S-1:0]     im_q [N];
  logic signed [S-1:0]     im_d [N];
  logic [N*S-1:0]          out_q, out_d;
  logic signed [T-1:0]     cos_tab [N];
  logic signed [T-1:0]     sin_tab [N];

  // Twiddle ROM holds round(cos/sin(2*pi*k/N) * no_float_mult); the +sin gives the conjugate twiddle.
  for (genvar k = 0; k < N; k++) begin : g_tw
    localparam real ANG = 2.0 * PI * k / N;
    localparam real CR  = $cos(ANG) * no_float_mult;
    localparam real SR  = $sin(ANG) * no_float_mult;
    localparam int  CI  = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
    localparam int  SI  = (SR >= 0.0) ? $rtoi(SR + 0.5) : -$rtoi(0.5 - SR);
    assign cos_tab[k] = T'(CI);
    assign sin_tab[k] = T'(SI);
  end

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) r[LOG2N-1-b] = v[b];
    return r;
  endfunction

  function automatic logic signed [S-1:0] fit(input logic signed [PW-1:0] v);
`ifdef IFFT_SATURATE_EN
    if (v > SMAX) return SMAX[S-1:0];
    if (v < SMIN) return SMIN[S-1:0];
    return v[S-1:0];
`else
    return v[S-1:0];
`endif
  endfunction

  logic [LOG2N-1:0]        half, mask, a_idx, b_idx, tw_idx;
  logic signed [PW-1:0]    ar_w, ai_w, br_w, bi_w, wr_w, wi_w, pr, pi, tr, ti;

  // Butterfly operand addressing: pair (a, a+2^s) inside groups of 2^(s+1).
  always_comb begin
    half   = LOG2N'(1) << stage_q;
    mask   = half - LOG2N'(1);
    a_idx  = ((bfly_q & ~mask) << 1) | (bfly_q & mask);
    b_idx  = a_idx | half;
    tw_idx = (bfly_q & mask) << (SW'(LOG2N - 1) - stage_q);
    ar_w   = PW'(re_q[a_idx]);
    ai_w   = PW'(im_q[a_idx]);
    br_w   = PW'(re_q[b_idx]);
    bi_w   = PW'(im_q[b_idx]);
    wr_w   = PW'(cos_tab[tw_idx]);
    wi_w   = PW'(sin_tab[tw_idx]);
    pr     = br_w * wr_w - bi_w * wi_w;
    pi     = br_w * wi_w + bi_w * wr_w;
    tr     = pr / NFM;
    ti     = pi / NFM;
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    re_d    = re_q;
    im_d    = im_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < N; k++) begin
            re_d[bitrev(LOG2N'(k))] = input_real[k*S +: S];
            im_d[bitrev(LOG2N'(k))] = input_imag[k*S +: S];
          end
          stage_d = '0;
          bfly_d  = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        re_d[a_idx] = fit(ar_w + tr);
        im_d[a_idx] = fit(ai_w + ti);
        re_d[b_idx] = fit(ar_w - tr);
        im_d[b_idx] = fit(ai_w - ti);
        if (bfly_q == LOG2N'(N/2 - 1)) begin
          bfly_d = '0;
          if (stage_q == SW'(LOG2N - 1)) begin
            stage_d = '0;
            state_d = SCALE;
          end else begin
            stage_d = stage_q + SW'(1);
          end
        end else begin
          bfly_d = bfly_q + LOG2N'(1);
        end
      end
      SCALE: begin
        for (int n = 0; n < N; n++) out_d[n*S +: S] = re_q[LOG2N'(n)] >>> LOG2N;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      bfly_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      out_q   <= out_d;
    end
  end

  // Working registers are pure datapath: contents are don't-care until a block is captured.
  always_ff @(posedge clk) begin
    re_q <= re_d;
    im_q <= im_d;
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign output_real = out_q;

endmodule
